// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, bubble encoding, opcodes and fetch FSM states.
package riscv_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

    // True for opcodes the main decoder recognises; the all-zero bubble is not among them.
    function automatic logic opcode_is_known(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two instruction return buffer with synchronous clear, push/pop and occupancy.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, credit-limited instruction memory requests, return buffer and IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_d flagging redirects to non-word-aligned targets.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            misalign_d
`endif
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = XLEN + 32;

    fetch_state_t     state, state_next;
    logic [XLEN-1:0]  pc_f;
    logic [XLEN-1:0]  ret_pc;
    logic [XLEN-1:0]  target_pc;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] kill_cnt;
    logic [CNT_W-1:0] kill_next;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0]   credit_used;
    logic             fifo_empty;
    logic             fifo_full;
    logic             grant;
    logic             ret_counted;
    logic             ret_drain;
    logic             push;
    logic             pop;
    logic             advance;
    logic [ENTRY_W-1:0] head_entry;

    assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, out_cnt};
    assign imem_addr   = pc_f;
    assign grant       = imem_req && imem_gnt;

    // A return only counts against outstanding work once something is actually in flight.
    assign ret_counted = imem_rvalid && (state != FETCH_IDLE) &&
                         ((out_cnt != '0) || (kill_cnt != '0));
    assign ret_drain   = imem_rvalid && (state == FETCH_DRAIN) && (kill_cnt != '0);
    assign push        = imem_rvalid && (state == FETCH_RUN) && !redirect_e && (out_cnt != '0);

    assign advance = !redirect_e && !flush_d && !stall_d;
    assign pop     = advance && !fifo_empty;

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        kill_next  = kill_cnt;

        if (redirect_e) begin
            kill_next = kill_cnt + out_cnt - CNT_W'(ret_counted);
        end else if (ret_drain) begin
            kill_next = kill_cnt - CNT_W'(1);
        end

        case (state)
            FETCH_IDLE: begin
                state_next = FETCH_RUN;
            end
            FETCH_RUN: begin
                imem_req = !redirect_e && !fifo_full &&
                           (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
                if (redirect_e && (kill_next != '0)) begin
                    state_next = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (!redirect_e && (kill_next == '0)) begin
                    state_next = FETCH_RUN;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            pc_f     <= RESET_PC;
            ret_pc   <= RESET_PC;
            out_cnt  <= '0;
            kill_cnt <= '0;
        end else begin
            state    <= state_next;
            kill_cnt <= kill_next;
            if (redirect_e) begin
                pc_f    <= target_pc;
                ret_pc  <= target_pc;
                out_cnt <= '0;
            end else begin
                if (grant) begin
                    pc_f <= pc_f + XLEN'(4);
                end
                // Responses come back in order, so the next return belongs to ret_pc.
                if (push) begin
                    ret_pc <= ret_pc + XLEN'(4);
                end
                out_cnt <= out_cnt + CNT_W'(grant) - CNT_W'(push);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_e),
        .push      (push),
        .push_data ({ret_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_cnt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // ---- IF/ID boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d   <= BUBBLE_INSTR;
            pc_d      <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else if (redirect_e || flush_d) begin
            instr_d   <= BUBBLE_INSTR;
            pc_d      <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else if (!stall_d) begin
            if (!fifo_empty) begin
                instr_d   <= head_entry[31:0];
                pc_d      <= head_entry[ENTRY_W-1:32];
                pcplus4_d <= head_entry[ENTRY_W-1:32] + XLEN'(4);
                valid_d   <= 1'b1;
            end else begin
                instr_d   <= BUBBLE_INSTR;
                pc_d      <= '0;
                pcplus4_d <= '0;
                valid_d   <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_pend;

    // The flag rides on the first real instruction loaded after the offending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_pend <= 1'b0;
            misalign_d    <= 1'b0;
        end else if (redirect_e) begin
            misalign_pend <= |redirect_pc[1:0];
            misalign_d    <= 1'b0;
        end else if (flush_d) begin
            misalign_d    <= 1'b0;
        end else if (!stall_d) begin
            if (pop) begin
                misalign_d    <= misalign_pend;
                misalign_pend <= 1'b0;
            end else begin
                misalign_d    <= 1'b0;
            end
        end
    end
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus redirect/misalign/wrap sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        flush_d;
    logic        redirect_e;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_d;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int lat   = 1;
    int cyc   = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .redirect_e  (redirect_e),
        .redirect_pc (redirect_pc),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pcplus4_d   (pcplus4_d),
        .valid_d     (valid_d)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_d  (misalign_d)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h0050_0093 ^ {pc[19:0], 12'h000};
    endfunction

    // In-order memory: a request granted in cycle c returns in cycle c+lat.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (reset) mq.delete();
            else if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
            @(posedge clk);
            #1;
            cyc++;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        redirect_e  = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        tick();
        check("rst_valid", {31'h0, valid_d}, 32'h0);
        check("rst_instr", instr_d, 32'h0);
        check("rst_pc", pc_d, 32'h0);
        check("rst_pc4", pcplus4_d, 32'h0);
        reset = 1'b0;
    endtask

    // Redirect right after reset, then follow the first two loaded instructions.
    task automatic redirect_seq(input logic [31:0] rpc);
        logic [31:0] exp_pc;
        int          seen;
        lat = 1;
        do_reset();
        exp_pc = {rpc[31:2], 2'b00};
        tick();
        redirect_e  = 1'b1;
        redirect_pc = rpc;
        @(negedge clk);
        check("rd_req_off", {31'h0, imem_req}, 32'h0);
        tick();
        redirect_e = 1'b0;
        @(negedge clk);
        check("rd_addr", imem_addr, exp_pc);
        seen = 0;
        for (int k = 0; k < 12 && seen < 2; k++) begin
            tick();
            if (valid_d) begin
                check("rd_pc", pc_d, exp_pc);
                check("rd_instr", instr_d, instr_of(exp_pc));
                check("rd_pc4", pcplus4_d, 32'(exp_pc + 32'd4));
`ifdef FETCH_MISALIGN_CHECK_EN
                check("rd_misalign", {31'h0, misalign_d}, (seen == 0) ? {31'h0, |rpc[1:0]} : 32'h0);
`endif
                exp_pc = 32'(exp_pc + 32'd4);
                seen++;
            end
        end
        check("rd_loads_seen", seen, 2);
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic        gnt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic s, input logic f, input logic g, input logic r,
                       input logic [31:0] a, input logic v, input logic [31:0] p);
        vecs.push_back('{s, f, g, r, a, v, p});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        int          first_k;
        int          loads;

        //   stall flush gnt  req  addr         valid pc_d
        add(0, 0, 1,  0, 32'h00,  0, 32'h00);  // IDLE
        add(0, 0, 1,  1, 32'h00,  0, 32'h00);
        add(0, 0, 1,  1, 32'h04,  0, 32'h00);
        add(0, 0, 1,  0, 32'h08,  1, 32'h00);  // credits exhausted
        add(0, 0, 1,  1, 32'h08,  1, 32'h04);
        add(0, 0, 1,  1, 32'h0C,  0, 32'h00);
        add(0, 0, 1,  0, 32'h10,  1, 32'h08);
        add(1, 0, 1,  1, 32'h10,  1, 32'h08);  // stall x3
        add(1, 0, 1,  0, 32'h14,  1, 32'h08);
        add(1, 0, 1,  0, 32'h14,  1, 32'h08);
        add(0, 0, 1,  0, 32'h14,  1, 32'h0C);
        add(0, 0, 1,  1, 32'h14,  1, 32'h10);
        add(0, 0, 1,  1, 32'h18,  0, 32'h00);
        add(0, 0, 1,  0, 32'h1C,  1, 32'h14);
        add(1, 1, 1,  1, 32'h1C,  0, 32'h00);  // flush beats stall
        add(0, 0, 1,  0, 32'h20,  1, 32'h18);
        add(0, 0, 0,  1, 32'h20,  1, 32'h1C);  // gnt low x5
        add(0, 0, 0,  1, 32'h20,  0, 32'h00);
        add(0, 0, 0,  1, 32'h20,  0, 32'h00);
        add(0, 0, 0,  1, 32'h20,  0, 32'h00);
        add(0, 0, 0,  1, 32'h20,  0, 32'h00);
        add(0, 0, 1,  1, 32'h20,  0, 32'h00);
        add(0, 0, 1,  1, 32'h24,  0, 32'h00);
        add(0, 0, 1,  0, 32'h28,  1, 32'h20);
        add(0, 0, 1,  1, 32'h28,  1, 32'h24);

        lat = 1;
        do_reset();
        foreach (vecs[i]) begin
            stall_d  = vecs[i].stall;
            flush_d  = vecs[i].flush;
            imem_gnt = vecs[i].gnt;
            @(negedge clk);
            check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            tick();
            exp_instr = vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : 32'h0;
            exp_pc4   = vecs[i].exp_valid ? 32'(vecs[i].exp_pc + 32'd4) : 32'h0;
            check($sformatf("v%0d_valid", i), {31'h0, valid_d}, {31'h0, vecs[i].exp_valid});
            check($sformatf("v%0d_pc", i), pc_d, vecs[i].exp_pc);
            check($sformatf("v%0d_instr", i), instr_d, exp_instr);
            check($sformatf("v%0d_pc4", i), pcplus4_d, exp_pc4);
        end
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        imem_gnt = 1'b1;

        // Redirect with two requests in flight: both stale returns must be dropped.
        lat = 3;
        do_reset();
        repeat (3) tick();
        redirect_e  = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check("rx_req_off", {31'h0, imem_req}, 32'h0);
        tick();
        redirect_e = 1'b0;
        check("rx_bubble_valid", {31'h0, valid_d}, 32'h0);
        check("rx_bubble_instr", instr_d, 32'h0);
        first_k = -1;
        loads   = 0;
        for (int k = 4; k < 24 && loads < 2; k++) begin
            @(negedge clk);
            if (k == 4 || k == 5) check("rx_drain_req", {31'h0, imem_req}, 32'h0);
            if (k == 6) begin
                check("rx_refetch_req", {31'h0, imem_req}, 32'h1);
                check("rx_refetch_addr", imem_addr, 32'h0000_0100);
            end
            tick();
            if (valid_d) begin
                if (loads == 0) first_k = k;
                check("rx_pc", pc_d, (loads == 0) ? 32'h100 : 32'h104);
                check("rx_instr", instr_d, instr_of(pc_d));
                loads++;
            end else begin
                check("rx_gap_instr", instr_d, 32'h0);
            end
        end
        check("rx_first_cycle", first_k, 10);
        check("rx_loads_seen", loads, 2);

        // Non-word-aligned target and a PC that wraps past the top of the address space.
        redirect_seq(32'h0000_0102);
        redirect_seq(32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
